led_pattern_gen: RTL and testbench
==================================

# led_pattern_gen

Parametrised LED pattern generator for the board's status LEDs. A prescaler divides `clk` down to a configurable step period. On each step, a pattern engine advances in one of four modes: binary count, Gray count, bounce scan, or ring rotate. Direction is selectable and the engine can be paused. The block drives the LED pins directly, with selectable output polarity, and replaces the fixed free-running binary LED counter used in earlier bring-up designs.

## Interface
- `WAIT_TIME`, 27000000, step period in `clk` cycles; must be ≥ 2.
- `LED_WIDTH`, 6, number of LEDs; must be ≥ 2.
- `ACTIVE_LOW`, 1, when 1 the internal pattern is inverted at the output; when 0 it is passed through.
- `clk` input 1: single clock for all logic.
- `reset` input 1: synchronous, active-high reset.
- `run` input 1: 1 means the prescaler runs; 0 means it holds (paused).
- `dir` input 1: 0 selects up/left, 1 selects down/right. It is sampled on each step.
- `mode` input 2: 0 BIN, 1 GRAY, 2 SCAN, 3 RING.
- `step` input 1: single-step request; present only with `LED_PATTERN_STEP_EN`.
- `tick` output 1: one-cycle pulse, high in the cycle the new pattern first appears on `led`.
- `led` output LED_WIDTH: the registered LED drive.

## Operation
**State**
- `presc`: prescaler, `$clog2(WAIT_TIME)` bits.
- `cnt`: LED_WIDTH bits.
- `oh`: one-hot register, LED_WIDTH bits.
- `scan_up`: scan direction, 1 bit.
- `mode_q`: registered mode, 2 bits.
- `led` and `tick`: output registers.

**Prescaler**
- When `run`=1, it counts 0 to WAIT_TIME-1 and then wraps to 0.
- An advance event fires in the cycle where `presc`==WAIT_TIME-1 and `run`=1.

**Advance by mode**
- BIN: `cnt` ← `cnt`+1 if `dir`=0, else `cnt`-1. Arithmetic is modulo 2^LED_WIDTH, so it wraps both ways (all-ones+1 gives 0; 0-1 gives all-ones).
- GRAY: `cnt` advances exactly as in BIN. The displayed pattern is `cnt ^ (cnt>>1)`.
- SCAN: `dir` is ignored. `oh` shifts left while `scan_up`=1 and right while `scan_up`=0.
  - When `oh` reaches the MSB, `scan_up` clears; the next advance moves to MSB-1.
  - When `oh` reaches bit 0, `scan_up` sets.
  - Sequence for LED_WIDTH=4: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, …
- RING: `oh` rotates left (`dir`=0) or right (`dir`=1), wrapping MSB↔bit 0.

**Other rules**
- Display pattern: `cnt` for BIN, Gray(`cnt`) for GRAY, `oh` for SCAN and RING.
- `led` ← pattern XOR {LED_WIDTH{ACTIVE_LOW}}.
- Mode change:
  - Trigger: `mode` != `mode_q` in any cycle.
  - In the following cycle, `cnt`=0, `oh`=1, `scan_up`=1 and `presc`=0.
  - `mode_q` is updated and no advance occurs in that cycle, even if the prescaler was at terminal count.
  - `tick` stays 0; `led` shows the new mode's initial pattern one cycle later.
- Pause: `run`=0 freezes `presc` and all pattern state. `led` holds. Resuming continues from the held `presc` value; the count is not restarted.

## Timing
**Reset values**
- `presc`=0, `cnt`=0, `oh`=1, `scan_up`=1, `mode_q`=`mode`.
- `tick`=0.
- `led` = 0 XOR polarity for modes 0/1, or 1 XOR polarity for modes 2/3. The mode used is the one sampled during reset.

**Latency and period**
- Advance event in cycle N: the state updates at the end of N; `led` and `tick` update at the end of N+1. Latency is 2 cycles from terminal count to the visible LED.
- With `run` held at 1, `tick` period is exactly WAIT_TIME cycles.
- The first `tick` after reset deassertion appears WAIT_TIME+1 cycles after the first non-reset edge.

**Boundary cases**
- Reset asserted mid-period: takes effect at the next `clk` edge and overrides every other input, including a mode change or step in the same cycle.
- Mode change and advance event in the same cycle: the mode change wins and the advance is dropped.
- `dir` toggled between steps: takes effect at the next advance. No glitch on `led`, because `led` is registered.

## Configuration
- Macro: `LED_PATTERN_STEP_EN`.
- Defined:
  - The `step` port exists. A rising edge on `step` is detected with a 1-cycle registered delay.
  - A rising edge while `run`=0 produces one advance event; `presc` is untouched.
  - Rising edges while `run`=1 are ignored.
  - A step edge coincident with a mode change is dropped.
- Undefined: the `step` port and its edge-detect register are absent. Advances come only from the prescaler.

## Test plan
All scenarios use WAIT_TIME=4, LED_WIDTH=4, ACTIVE_LOW=1.
- Reset, `mode`=0, `dir`=0, `run`=1 → `led`=1111 after reset. `tick` every 4 cycles. `led` sequence 1110, 1101, 1100, … and `cnt` wraps 1111→0000, shown as `led` 0000→1111.
- `mode`=0, `dir`=1 from reset → `cnt` sequence 1111, 1110, …, with `led` 0000, 0001, …. Confirms underflow wrap.
- `mode`=1 for 16 ticks → exactly one bit changes between consecutive `led` values. The sequence returns to `led`=1111 (Gray 0000) at tick 16.
- `mode`=2 for 8 ticks → internal `oh` sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010 regardless of `dir`. No duplicated endpoint.
- `mode`=3, `dir`=1 → `oh` sequence 0001, 1000, 0100, 0010, 0001. Then switch to `mode`=0 in the cycle `presc`==3 → no `tick`, `cnt`=0, and the next `tick` comes 4 cycles after the reinit cycle.
- `run`=0 for 20 cycles mid-period → `led` and `presc` frozen. With `LED_PATTERN_STEP_EN`, each rising edge on `step` produces one advance and one `tick`; pulses with `run`=1 produce no extra advance.

Source files
------------

// File: rtl/led_pattern_gen.sv
// Status-LED pattern generator: prescaled step engine with BIN / GRAY / SCAN / RING modes.
// Optional single-step input is compiled in with `define LED_PATTERN_STEP_EN.
module led_pattern_gen #(
    parameter int WAIT_TIME  = 27000000,
    parameter int LED_WIDTH  = 6,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 dir,
    input  logic [1:0]           mode,
`ifdef LED_PATTERN_STEP_EN
    input  logic                 step,
`endif
    output logic                 tick,
    output logic [LED_WIDTH-1:0] led
);

    localparam int                   PW         = $clog2(WAIT_TIME);
    localparam logic [PW-1:0]        PRESC_LAST = PW'(WAIT_TIME - 1);
    localparam logic [LED_WIDTH-1:0] POL        = {LED_WIDTH{ACTIVE_LOW}};
    localparam logic [LED_WIDTH-1:0] OH_INIT    = LED_WIDTH'(1);

    typedef enum logic [1:0] {
        M_BIN  = 2'd0,
        M_GRAY = 2'd1,
        M_SCAN = 2'd2,
        M_RING = 2'd3
    } mode_e;

    logic [PW-1:0]        presc_q, presc_d;
    logic [LED_WIDTH-1:0] cnt_q, cnt_d;
    logic [LED_WIDTH-1:0] oh_q, oh_d;
    logic                 scan_up_q, scan_up_d;
    logic [1:0]           mode_q, mode_d;
    logic                 adv_q, adv_d;
    logic                 tick_q, tick_d;
    logic [LED_WIDTH-1:0] led_q, led_d;

    logic                 mode_chg;
    logic                 presc_term;
    logic                 step_adv;
    logic [LED_WIDTH-1:0] pattern;

`ifdef LED_PATTERN_STEP_EN
    logic step_q;

    always_ff @(posedge clk) begin
        step_q <= step;
    end

    // Manual stepping only while paused; the prescaler position is left alone.
    always_comb begin
        step_adv = !run && step && !step_q;
    end
`else
    always_comb begin
        step_adv = 1'b0;
    end
`endif

    always_comb begin
        mode_chg   = (mode != mode_q);
        presc_term = run && (presc_q == PRESC_LAST);
        // A mode change reinitialises everything and swallows any coincident advance.
        adv_d      = !mode_chg && (presc_term || step_adv);

        presc_d   = presc_q;
        cnt_d     = cnt_q;
        oh_d      = oh_q;
        scan_up_d = scan_up_q;
        mode_d    = mode_q;

        if (mode_chg) begin
            presc_d   = '0;
            cnt_d     = '0;
            oh_d      = OH_INIT;
            scan_up_d = 1'b1;
            mode_d    = mode;
        end else begin
            if (run) begin
                presc_d = presc_term ? '0 : presc_q + PW'(1);
            end
            if (adv_d) begin
                case (mode_e'(mode_q))
                    M_BIN, M_GRAY: begin
                        cnt_d = dir ? cnt_q - LED_WIDTH'(1) : cnt_q + LED_WIDTH'(1);
                    end
                    M_SCAN: begin
                        if (scan_up_q) begin
                            oh_d = oh_q << 1;
                            if (oh_d[LED_WIDTH-1]) scan_up_d = 1'b0;
                        end else begin
                            oh_d = oh_q >> 1;
                            if (oh_d[0]) scan_up_d = 1'b1;
                        end
                    end
                    default: begin
                        oh_d = dir ? {oh_q[0], oh_q[LED_WIDTH-1:1]}
                                   : {oh_q[LED_WIDTH-2:0], oh_q[LED_WIDTH-1]};
                    end
                endcase
            end
        end
    end

    // Display path is one register behind the state, so tick follows the delayed advance.
    always_comb begin
        case (mode_e'(mode_q))
            M_BIN:   pattern = cnt_q;
            M_GRAY:  pattern = cnt_q ^ (cnt_q >> 1);
            default: pattern = oh_q;
        endcase
        led_d  = pattern ^ POL;
        tick_d = adv_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q   <= '0;
            cnt_q     <= '0;
            oh_q      <= OH_INIT;
            scan_up_q <= 1'b1;
            mode_q    <= mode;
            adv_q     <= 1'b0;
            tick_q    <= 1'b0;
            led_q     <= (mode[1] ? OH_INIT : '0) ^ POL;
        end else begin
            presc_q   <= presc_d;
            cnt_q     <= cnt_d;
            oh_q      <= oh_d;
            scan_up_q <= scan_up_d;
            mode_q    <= mode_d;
            adv_q     <= adv_d;
            tick_q    <= tick_d;
            led_q     <= led_d;
        end
    end

    assign tick = tick_q;
    assign led  = led_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (WAIT_TIME=4, LED_WIDTH=4, ACTIVE_LOW=1).
// An abstract model predicts led/tick every cycle; directed checks pin key literals.
module tb_led_pattern_gen;
    localparam int WT = 4;
    localparam int W  = 4;

    logic         clk = 1'b0;
    logic         reset, run, dir;
    logic [1:0]   mode;
    logic         tick;
    logic [W-1:0] led;
`ifdef LED_PATTERN_STEP_EN
    logic         step;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(.WAIT_TIME(WT), .LED_WIDTH(W), .ACTIVE_LOW(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .dir   (dir),
        .mode  (mode),
`ifdef LED_PATTERN_STEP_EN
        .step  (step),
`endif
        .tick  (tick),
        .led   (led)
    );

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: BIN/GRAY hold a counter value, SCAN holds the number of advances
    // into its bounce cycle, RING holds the lit bit index.
    int           m_presc, m_val, m_mode;
    bit           m_pend, m_tick, m_valid = 1'b0, m_step_prev = 1'b0;
    logic [W-1:0] m_led;

    function automatic logic [W-1:0] disp(input int md, input int v);
        int p;
        case (md)
            0: return W'(v);
            1: return W'(v ^ (v >> 1));
            2: begin
                p = (v <= W - 1) ? v : 2 * (W - 1) - v;
                return W'(1 << p);
            end
            default: return W'(1 << v);
        endcase
    endfunction

    always @(posedge clk) begin : model
        bit adv;
        adv = 1'b0;
        if (reset) begin
            m_presc = 0;
            m_val   = 0;
            m_mode  = int'(mode);
            m_pend  = 1'b0;
            m_tick  = 1'b0;
            m_led   = disp(int'(mode), 0) ^ {W{1'b1}};
            m_valid = 1'b1;
        end else begin
            m_led  = disp(m_mode, m_val) ^ {W{1'b1}};
            m_tick = m_pend;
            m_pend = 1'b0;
            if (int'(mode) != m_mode) begin
                m_mode  = int'(mode);
                m_val   = 0;
                m_presc = 0;
            end else begin
                if (run) begin
                    adv     = (m_presc == WT - 1);
                    m_presc = (m_presc + 1) % WT;
                end
`ifdef LED_PATTERN_STEP_EN
                else if (step && !m_step_prev) adv = 1'b1;
`endif
                if (adv) begin
                    m_pend = 1'b1;
                    case (m_mode)
                        0, 1: m_val = dir ? (m_val + (1 << W) - 1) % (1 << W) : (m_val + 1) % (1 << W);
                        2:    m_val = (m_val + 1) % (2 * (W - 1));
                        default: m_val = dir ? (m_val + W - 1) % W : (m_val + 1) % W;
                    endcase
                end
            end
        end
`ifdef LED_PATTERN_STEP_EN
        m_step_prev = step;
`endif
    end

    always @(posedge clk) begin
        #1;
        if (m_valid) begin
            chk("model_led", led, m_led);
            chk("model_tick", W'(tick), W'(m_tick));
        end
    end

    task automatic wait_tick(output logic [W-1:0] l, output int cyc);
        cyc = 0;
        l   = 'x;
        repeat (6 * WT) begin
            @(posedge clk);
            #1;
            cyc++;
            if (tick) begin
                l = led;
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL tick_timeout: no tick within %0d cycles", 6 * WT);
    endtask

    logic [W-1:0] l, prev, held;
    int           cyc;
    logic [W-1:0] scan_oh [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                  4'b0010, 4'b0001, 4'b0010, 4'b0100};
    logic [W-1:0] ring_oh [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

    initial begin
        reset = 1'b1; run = 1'b1; dir = 1'b0; mode = 2'd0;
`ifdef LED_PATTERN_STEP_EN
        step = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_led", led, 4'b1111);
        chk("reset_tick", W'(tick), '0);
        reset = 1'b0;

        // BIN up: first ticks, period, then overflow wrap.
        wait_tick(l, cyc); chk("bin_t1", l, 4'b1110);
        wait_tick(l, cyc); chk("bin_t2", l, 4'b1101); chk("bin_period", W'(cyc), W'(WT));
        wait_tick(l, cyc); chk("bin_t3", l, 4'b1100);
        repeat (12) wait_tick(l, cyc);
        chk("bin_t15", l, 4'b0000);
        wait_tick(l, cyc); chk("bin_wrap", l, 4'b1111);

        // BIN down from reset: underflow wrap.
        @(negedge clk); reset = 1'b1; dir = 1'b1;
        @(negedge clk); reset = 1'b0;
        wait_tick(l, cyc); chk("bin_dn_t1", l, 4'b0000);
        wait_tick(l, cyc); chk("bin_dn_t2", l, 4'b0001);

        // GRAY: single-bit changes, back to Gray 0 after 16 ticks.
        @(negedge clk); dir = 1'b0; mode = 2'd1;
        prev = 4'b1111;
        for (int i = 1; i <= 16; i++) begin
            wait_tick(l, cyc);
            chk("gray_onebit", W'($countones(l ^ prev)), W'(1));
            prev = l;
        end
        chk("gray_t16", l, 4'b1111);

        // SCAN: bounce ignores dir.
        @(negedge clk); mode = 2'd2;
        for (int i = 0; i < 8; i++) begin
            wait_tick(l, cyc);
            chk("scan_seq", ~l, scan_oh[i]);
            @(negedge clk); dir = ~dir;
        end

        // RING right, then switch to BIN exactly when presc is at terminal count.
        @(negedge clk); dir = 1'b1; mode = 2'd3;
        for (int i = 0; i < 4; i++) begin
            wait_tick(l, cyc);
            chk("ring_seq", ~l, ring_oh[i]);
        end
        repeat (3) @(negedge clk);
        mode = 2'd0;
        dir  = 1'b0;
        wait_tick(l, cyc);
        chk("modechg_latency", W'(cyc), W'(6));
        chk("modechg_led", l, 4'b1110);

        // Pause mid-period: everything freezes, resume continues from held presc.
        @(negedge clk);
        run  = 1'b0;
        held = led;
        repeat (20) @(negedge clk);
        chk("pause_hold", led, held);
`ifdef LED_PATTERN_STEP_EN
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; @(negedge clk);
            step = 1'b0;
            wait_tick(l, cyc);
            chk("step_tick", W'(cyc <= 2), W'(1));
            @(negedge clk);
        end
`endif
        run = 1'b1;
        wait_tick(l, cyc);
        chk("resume_latency", W'(cyc), W'(4));
`ifdef LED_PATTERN_STEP_EN
        @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
        repeat (3) @(negedge clk); step = 1'b1;
        @(negedge clk); step = 1'b0;
`endif
        repeat (2 * WT) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
